regdump_controller: RTL and testbench
=====================================

REGDUMP_CONTROLLER -- requirements
Module: regdump_controller

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter FIRST_REG, default 0: first register address dumped.
REQ-003 Parameter LAST_REG, default 31: last register address dumped; FIRST_REG <= LAST_REG <= 31 required.
REQ-004 clock  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-006 start  input  1  level; sampled in IDLE to begin a dump.
REQ-007 abort  input  1  level; terminates a dump in progress.
REQ-008 read_data_debug  input  32  register-file debug read data.
REQ-009 dump_ready  input  1  sink can accept dump_byte this cycle.
REQ-010 read_address_debug  output  5  register-file debug read address.
REQ-011 clock_debug  output  1  registered strobe to the register-file debug port; rising edge captures read data.
REQ-012 dump_byte  output  8  outgoing byte.
REQ-013 dump_valid  output  1  dump_byte is valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at normal completion.

Function
REQ-016 States SHALL be IDLE, ADDR, STROBE, CAPTURE, SEND, NEXT, DONE.
REQ-017 IDLE -> ADDR when start=1; read_address_debug loads FIRST_REG; start in any other state is ignored.
REQ-018 ADDR -> STROBE unconditionally; clock_debug=0.
REQ-019 STROBE -> CAPTURE unconditionally; clock_debug=1 in STROBE only, 0 in all other states.
REQ-020 CAPTURE: read_data_debug latched into a 32-bit word register at the CAPTURE-ending edge; -> SEND.
REQ-021 read_address_debug SHALL be held stable from ADDR through NEXT.
REQ-022 SEND: five-byte frame per register, in order: {3'b000, address}, data[31:24], data[23:16], data[15:8], data[7:0].
REQ-023 dump_valid=1 throughout SEND; transfer occurs on an edge where dump_valid=1 and dump_ready=1.
REQ-024 dump_byte SHALL hold stable while dump_valid=1 and dump_ready=0; no byte skipped or repeated.
REQ-025 After the fifth transfer -> NEXT; dump_valid=0 in NEXT.
REQ-026 NEXT: if address == LAST_REG -> DONE; else address increments by 1 -> ADDR; no wrap past LAST_REG.
REQ-027 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-028 abort=1 in any state other than IDLE or DONE -> IDLE on the next edge; dump_valid, clock_debug, done = 0; partial frame discarded.
REQ-029 abort and start both high in IDLE: start wins; abort has no effect in IDLE.
REQ-030 With dump_ready held 1, each register takes exactly 9 cycles (ADDR, STROBE, CAPTURE, 5 SEND, NEXT).

Reset
REQ-031 On reset low: state=IDLE, read_address_debug=0, clock_debug=0, dump_byte=0, dump_valid=0, busy=0, done=0, word register=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the block waits in IDLE for start.

Verification
REQ-033 Register file preloaded r[i]=i*0x01010101, dump_ready=1, start pulse -> 160 bytes; frame 5 = 05,05,05,05,05; done 289 cycles after start edge.
REQ-034 dump_ready toggling 1-of-3 cycles during the REQ-033 dump -> identical 160-byte stream, no duplicates, dump_byte stable while stalled.
REQ-035 FIRST_REG=30, LAST_REG=31, r30=0xDEADBEEF -> 1E,DE,AD,BE,EF,1F,… then done; address never reaches 0.
REQ-036 abort asserted after the second byte of register 3 -> next cycle IDLE, busy=0, dump_valid=0, done never pulses.
REQ-037 reset low during SEND of register 7 -> all outputs at REQ-031 values immediately; new start restarts at FIRST_REG.
REQ-038 start held high through a whole dump -> second dump begins in the cycle after DONE; clock_debug pulses exactly once per register.

Source files
------------

// File: rtl/regdump_controller.sv
// Register-file dump sequencer: strobes each debug register from FIRST_REG to LAST_REG
// and streams a five-byte frame {address, data MSB..LSB} per register over a valid/ready byte port.
module regdump_controller #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] read_data_debug,
  input  logic        dump_ready,
  output logic [4:0]  read_address_debug,
  output logic        clock_debug,
  output logic [7:0]  dump_byte,
  output logic        dump_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STROBE, S_CAPTURE, S_SEND, S_NEXT, S_DONE
  } state_t;

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  state_t      state;
  logic [31:0] word;
  logic [2:0]  byte_idx;  // index of the byte currently on dump_byte, 0 = address byte

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd1:    b = w[31:24];
      3'd2:    b = w[23:16];
      3'd3:    b = w[15:8];
      3'd4:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // NOTE: every register below is updated with <= so all of them see the pre-edge
  // values of each other; blocking assignments here would create ordering races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      read_address_debug <= 5'd0;
      clock_debug        <= 1'b0;
      dump_byte          <= 8'h00;
      dump_valid         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      word               <= 32'h0;
      byte_idx           <= 3'd0;
    end else if (abort && state != S_IDLE && state != S_DONE) begin
      // Partial frame is dropped; address and word keep their stale values.
      state       <= S_IDLE;
      clock_debug <= 1'b0;
      dump_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state              <= S_ADDR;
            read_address_debug <= FIRST_ADDR;
            busy               <= 1'b1;
          end
        end
        S_ADDR: begin
          state       <= S_STROBE;
          clock_debug <= 1'b1;
        end
        S_STROBE: begin
          state       <= S_CAPTURE;
          clock_debug <= 1'b0;
        end
        S_CAPTURE: begin
          state      <= S_SEND;
          word       <= read_data_debug;
          dump_byte  <= {3'b000, read_address_debug};
          dump_valid <= 1'b1;
          byte_idx   <= 3'd0;
        end
        S_SEND: begin
          if (dump_ready) begin
            if (byte_idx == 3'd4) begin
              state      <= S_NEXT;
              dump_valid <= 1'b0;
            end else begin
              byte_idx  <= byte_idx + 3'd1;
              dump_byte <= word_byte(word, byte_idx + 3'd1);
            end
          end
        end
        S_NEXT: begin
          if (read_address_debug == LAST_ADDR) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state              <= S_ADDR;
            read_address_debug <= read_address_debug + 5'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regdump_controller.sv
// Scoreboard bench for regdump_controller: a default-range instance plus a 30..31 instance,
// each fed by a register-file model that responds to the clock_debug rising edge.
module tb_regdump_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dump_ready = 1'b1;
  logic [31:0] read_data_debug = 32'h0;
  logic [4:0]  read_address_debug;
  logic        clock_debug;
  logic [7:0]  dump_byte;
  logic        dump_valid;
  logic        busy;
  logic        done;

  logic        start2 = 1'b0;
  logic [31:0] read_data_debug2 = 32'h0;
  logic [4:0]  read_address_debug2;
  logic        clock_debug2;
  logic [7:0]  dump_byte2;
  logic        dump_valid2;
  logic        busy2;
  logic        done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];
  int  xfer_total = 0;
  int  cd_total   = 0;
  int  done_total = 0;
  int  cyc        = 0;
  bit  stall_mode = 1'b0;
  bit  stalled_prev = 1'b0;
  logic [7:0] held_byte = 8'h00;

  regdump_controller dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .read_data_debug(read_data_debug), .dump_ready(dump_ready),
    .read_address_debug(read_address_debug), .clock_debug(clock_debug),
    .dump_byte(dump_byte), .dump_valid(dump_valid), .busy(busy), .done(done)
  );

  regdump_controller #(.FIRST_REG(30), .LAST_REG(31)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .abort(1'b0),
    .read_data_debug(read_data_debug2), .dump_ready(1'b1),
    .read_address_debug(read_address_debug2), .clock_debug(clock_debug2),
    .dump_byte(dump_byte2), .dump_valid(dump_valid2), .busy(busy2), .done(done2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Register-file models: r[i] = i * 0x01010101, and for the second instance r30 = DEADBEEF.
  always @(posedge clock_debug) begin
    read_data_debug <= 32'(read_address_debug) * 32'h01010101;
    cd_total <= cd_total + 1;
  end

  always @(posedge clock_debug2) begin
    read_data_debug2 <= (read_address_debug2 == 5'd30) ? 32'hDEADBEEF
                                                       : 32'(read_address_debug2) * 32'h01010101;
    check("addr2_range", 32'(read_address_debug2 >= 5'd30), 32'd1);
  end

  always @(posedge clock) if (done) done_total <= done_total + 1;

  // Sink handshake: ready always, or one cycle in three when stalling.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      dump_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Byte monitor, sampled mid-cycle: a transfer is valid & ready with no abort pending.
  always @(negedge clock) begin
    if (reset && stalled_prev) begin
      check("stall_valid", 32'(dump_valid), 32'd1);
      check("stall_hold", 32'(dump_byte), 32'(held_byte));
    end
    if (reset && dump_valid && dump_ready && !abort) begin
      if (exp_q.size() == 0) check("extra_byte", 32'(dump_byte), 32'hFFFF_FFFF);
      else check("dump_byte", 32'(dump_byte), 32'(exp_q.pop_front()));
      xfer_total++;
    end
    stalled_prev = reset && dump_valid && !dump_ready && !abort;
    held_byte    = dump_byte;
    if (reset && dump_valid2) begin
      if (exp_q2.size() == 0) check("extra_byte2", 32'(dump_byte2), 32'hFFFF_FFFF);
      else check("dump_byte2", 32'(dump_byte2), 32'(exp_q2.pop_front()));
    end
  end

  task automatic push_frames(input int first, input int last, input bit second);
    logic [31:0] w;
    for (int a = first; a <= last; a++) begin
      w = (second && a == 30) ? 32'hDEADBEEF : a * 32'h01010101;
      if (second) exp_q2.push_back(8'(a));
      else        exp_q.push_back(8'(a));
      for (int b = 3; b >= 0; b--) begin
        if (second) exp_q2.push_back(w[b*8 +: 8]);
        else        exp_q.push_back(w[b*8 +: 8]);
      end
    end
  endtask

  // Counts edges from the start edge (which is edge 1) until done is seen after an edge.
  task automatic wait_done(input int budget, input bit hold_start, output int n);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      #1;
      start = hold_start;
    end while (!done && n < budget);
    if (!done) check("done_timeout", 32'(n), 32'(budget + 1));
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (xfer_total < target && n < budget);
    if (xfer_total < target) check("xfer_timeout", 32'(xfer_total), 32'(target));
  endtask

  initial begin
    int n;
    int base;
    int cd_base;
    int done_base;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_byte", 32'(dump_byte), 32'd0);
    check("rst_addr", 32'(read_address_debug), 32'd0);
    check("rst_cdbg", 32'(clock_debug), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Full dump with ready held high: 32 x 9 cycles, then the DONE cycle.
    push_frames(0, 31, 1'b0);
    base = xfer_total;
    start = 1'b1;
    wait_done(400, 1'b0, n);
    check("dump_cycles", 32'(n), 32'd289);
    check("dump_bytes", 32'(xfer_total - base), 32'd160);
    check("dump_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Same dump with the sink stalling two cycles in three.
    stall_mode = 1'b1;
    push_frames(0, 31, 1'b0);
    base = xfer_total;
    start = 1'b1;
    wait_done(2000, 1'b0, n);
    check("stall_bytes", 32'(xfer_total - base), 32'd160);
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);
    stall_mode = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Narrow-range instance: registers 30 and 31 only.
    push_frames(30, 31, 1'b1);
    start2 = 1'b1;
    n = 0;
    do begin
      @(posedge clock); n++; #1; start2 = 1'b0;
    end while (!done2 && n < 100);
    check("dump2_cycles", 32'(n), 32'd19);
    check("dump2_q_empty", 32'(exp_q2.size()), 32'd0);
    check("dump2_final_addr", 32'(read_address_debug2), 32'd31);

    // Abort after the second byte of register 3 (transfer 17 of the dump).
    push_frames(0, 31, 1'b0);
    base = xfer_total;
    done_base = done_total;
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_xfers(base + 17, 400);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(dump_valid), 32'd0);
    check("abort_cdbg", 32'(clock_debug), 32'd0);
    check("abort_bytes", 32'(xfer_total - base), 32'd17);
    exp_q.delete();
    repeat (20) @(posedge clock);
    #1;
    check("abort_no_done", 32'(done_total - done_base), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // Asynchronous reset during the SEND of register 7.
    push_frames(0, 31, 1'b0);
    base = xfer_total;
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_xfers(base + 36, 400);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_byte", 32'(dump_byte), 32'd0);
    check("mid_rst_addr", 32'(read_address_debug), 32'd0);
    check("mid_rst_cdbg", 32'(clock_debug), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    // Restart with start held high: full dump, then a second dump right after DONE.
    push_frames(0, 31, 1'b0);
    cd_base = cd_total;
    start = 1'b1;
    wait_done(400, 1'b1, n);
    check("held_cycles", 32'(n), 32'd289);
    check("held_q_empty", 32'(exp_q.size()), 32'd0);
    check("held_strobes", 32'(cd_total - cd_base), 32'd32);
    @(posedge clock); #1;
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_done_low", 32'(done), 32'd0);
    @(posedge clock); #1;
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_addr", 32'(read_address_debug), 32'd0);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("held_abort_busy", 32'(busy), 32'd0);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
